// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx
// Brief    : Buffered 8N1 UART transmitter. A valid/ready FIFO feeds a baud
//            counter and a frame FSM that drives TXD LSB-first.
//            Define UART_TX_PARITY_EN for 8E1 framing with an even-parity bit.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx #(
    parameter int BAUD_DIV   = 104,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [7:0]                    tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          TXD,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int c_ADDR_W = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W  = c_ADDR_W + 1;
    localparam int c_BAUD_W = $clog2(BAUD_DIV);

    localparam logic [c_CNT_W-1:0]  c_FULL      = c_CNT_W'(FIFO_DEPTH);
    localparam logic [c_BAUD_W-1:0] c_BAUD_LAST = c_BAUD_W'(BAUD_DIV - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd4
    } state_t;
`endif

    // FIFO storage and bookkeeping
    logic [7:0]          r_mem [FIFO_DEPTH];
    logic [c_ADDR_W-1:0] r_wr_ptr;
    logic [c_ADDR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0]  r_count;
    logic                r_tx_ready;

    // Frame engine
    state_t              r_state;
    logic [c_BAUD_W-1:0] r_baud_cnt;
    logic [2:0]          r_bit_idx;
    logic [7:0]          r_sh;
    logic                r_txd;
    logic                r_busy;
`ifdef UART_TX_PARITY_EN
    logic                r_parity;
`endif

    logic                w_push;
    logic                w_pop;
    logic                w_bit_end;
    logic                w_fifo_empty;
    logic [7:0]          w_head;
    logic [c_CNT_W-1:0]  w_count_next;

    assign w_fifo_empty = (r_count == '0);
    assign w_bit_end    = (r_baud_cnt == c_BAUD_LAST);
    assign w_head       = r_mem[r_rd_ptr];
    assign w_push       = tx_valid & r_tx_ready;
    // Pops happen only from IDLE or at the very end of a STOP bit, so the
    // next frame's START follows the previous STOP with no idle gap.
    assign w_pop        = !w_fifo_empty &&
                          ((r_state == IDLE) || ((r_state == STOP) && w_bit_end));

    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + 1'b1;
            2'b01:   w_count_next = r_count - 1'b1;
            default: w_count_next = r_count;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_tx_ready <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count    <= w_count_next;
            r_tx_ready <= (w_count_next != c_FULL);
        end
    end

    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= tx_data;
        end
    end

    // TXD and busy are registered from the current state, so the line view
    // trails the FSM by one cycle: a pop at edge N+1 drops TXD at edge N+2.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= IDLE;
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
            r_sh       <= '0;
            r_txd      <= 1'b1;
            r_busy     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_parity   <= 1'b0;
`endif
        end else begin
            r_busy <= (r_state != IDLE) || !w_fifo_empty || w_push;

            if ((r_state == IDLE) || w_bit_end) begin
                r_baud_cnt <= '0;
            end else begin
                r_baud_cnt <= r_baud_cnt + 1'b1;
            end

            case (r_state)
                IDLE: begin
                    r_txd <= 1'b1;
                    if (w_pop) begin
                        r_sh      <= w_head;
                        r_bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
                        r_parity  <= ^w_head;
`endif
                        r_state   <= START;
                    end
                end

                START: begin
                    r_txd <= 1'b0;
                    if (w_bit_end) begin
                        r_state <= DATA;
                    end
                end

                DATA: begin
                    r_txd <= r_sh[0];
                    if (w_bit_end) begin
                        r_sh      <= {1'b0, r_sh[7:1]};
                        r_bit_idx <= r_bit_idx + 3'd1;
                        if (r_bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            r_state <= PARITY;
`else
                            r_state <= STOP;
`endif
                        end
                    end
                end

`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    r_txd <= r_parity;
                    if (w_bit_end) begin
                        r_state <= STOP;
                    end
                end
`endif

                STOP: begin
                    r_txd <= 1'b1;
                    if (w_bit_end) begin
                        if (w_pop) begin
                            r_sh      <= w_head;
                            r_bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
                            r_parity  <= ^w_head;
`endif
                            r_state   <= START;
                        end else begin
                            r_state   <= IDLE;
                        end
                    end
                end

                default: begin
                    r_txd   <= 1'b1;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign tx_ready   = r_tx_ready;
    assign TXD        = r_txd;
    assign busy       = r_busy;
    assign fifo_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx
// Brief    : Scoreboard bench for uart_tx: stimulus queues hand-computed
//            frames, a line monitor decodes TXD and compares them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx;

    localparam int B     = 4;
    localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * B;

    logic       CLK;
    logic       RST;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       TXD;
    logic       busy;
    logic [2:0] fifo_count;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [10:0] exp_q[$];
    int          starts[$];

    // Frames are {stop, [parity,] d7..d0, start}; bit 0 is sent first.
    logic [7:0]  burst_d [5] = '{8'h00, 8'hFF, 8'h55, 8'h0F, 8'h3C};
`ifdef UART_TX_PARITY_EN
    logic [10:0] burst_f [5] = '{11'b10000000000, 11'b10111111110, 11'b10010101010,
                                 11'b10000011110, 11'b10001111000};
    logic [10:0] f_a5        = 11'b10101001010;
`else
    logic [10:0] burst_f [5] = '{11'b01000000000, 11'b01111111110, 11'b01010101010,
                                 11'b01000011110, 11'b01001111000};
    logic [10:0] f_a5        = 11'b01101001010;
`endif

    uart_tx #(
        .BAUD_DIV   (B),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .TXD        (TXD),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Called at a negedge; returns at the negedge following the accept edge.
    task automatic push(input logic [7:0] d, input logic [10:0] f, input bit track,
                        output int acc, output int cnt_rdy);
        int guard;
        guard    = 0;
        tx_data  = d;
        tx_valid = 1'b1;
        while (tx_ready !== 1'b1 && guard < 2000) begin
            @(negedge CLK);
            guard++;
        end
        if (tx_ready !== 1'b1) begin
            n_vec++;
            n_err++;
            $display("FAIL push_timeout: tx_ready %b, expected 1", tx_ready);
        end
        cnt_rdy = int'(fifo_count);
        acc     = cyc + 1;
        if (track) exp_q.push_back(f);
        @(negedge CLK);
    endtask

    task automatic wait_idle(output int t);
        int guard;
        guard = 0;
        while (busy !== 1'b0 && guard < 2000) begin
            @(negedge CLK);
            guard++;
        end
        if (busy !== 1'b0) begin
            n_vec++;
            n_err++;
            $display("FAIL idle_timeout: busy %b, expected 0", busy);
        end
        t = cyc;
    endtask

    // Line monitor: detects a start bit, samples every bit centre, then
    // checks the decoded frame against the head of the scoreboard queue.
    initial begin : monitor
        logic [10:0] got;
        logic [10:0] want;
        int          t0;
        int          ph;
        bit          in_frame;
        in_frame = 1'b0;
        got      = '0;
        t0       = 0;
        forever begin
            @(negedge CLK);
            if (RST === 1'b1) begin
                in_frame = 1'b0;
            end else begin
                if (!in_frame && TXD === 1'b0) begin
                    in_frame = 1'b1;
                    t0       = cyc;
                    got      = '0;
                    starts.push_back(cyc);
                end
                if (in_frame) begin
                    ph = cyc - t0;
                    if (ph % B == B / 2) begin
                        got[ph / B] = TXD;
                        if (ph / B == NBITS - 1) begin
                            in_frame = 1'b0;
                            n_vec++;
                            if (exp_q.size() == 0) begin
                                n_err++;
                                $display("FAIL unexpected_frame: got %b, expected no frame", got);
                            end else begin
                                want = exp_q.pop_front();
                                if (got !== want) begin
                                    n_err++;
                                    $display("FAIL frame: got %b, expected %b", got, want);
                                end
                            end
                        end
                    end
                end
            end
        end
    end

    initial begin : stimulus
        int acc;
        int cr;
        int t_idle;
        int guard;
        int t_rst;
        bit low_seen;

        RST      = 1'b1;
        tx_valid = 1'b0;
        tx_data  = 8'h00;

        // Reset state
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk("rst_txd", TXD, 1);
            chk("rst_busy", busy, 0);
            chk("rst_ready", tx_ready, 0);
        end
        RST = 1'b0;
        @(negedge CLK);
        chk("post_rst_ready", tx_ready, 1);
        chk("post_rst_count", fifo_count, 0);

        // Single byte 0xA5
        starts.delete();
        push(8'hA5, f_a5, 1'b1, acc, cr);
        tx_valid = 1'b0;
        chk("single_count", fifo_count, 1);
        wait_idle(t_idle);
        chk("single_starts", starts.size(), 1);
        if (starts.size() > 0) begin
            chk("single_latency", starts[0] - acc, 2);
            chk("single_busy_fall", t_idle - starts[0], FRAME);
        end

        // Burst of five with tx_valid held
        @(negedge CLK);
        starts.delete();
        for (int i = 0; i < 5; i++) push(burst_d[i], burst_f[i], 1'b1, acc, cr);
        tx_valid = 1'b0;
        chk("burst_full_count", fifo_count, 4);
        chk("burst_full_ready", tx_ready, 0);
        wait_idle(t_idle);
        chk("burst_starts", starts.size(), 5);
        for (int i = 1; i < starts.size(); i++) chk("burst_gap", starts[i] - starts[i-1], FRAME);
        if (starts.size() > 0) chk("burst_total", t_idle - starts[0], 5 * FRAME);

        // Push while full coinciding with a pop
        @(negedge CLK);
        for (int i = 0; i < 5; i++) push(burst_d[i], burst_f[i], 1'b1, acc, cr);
        chk("full_ready_low", tx_ready, 0);
        push(8'hA5, f_a5, 1'b1, acc, cr);
        tx_valid = 1'b0;
        chk("full_pop_count", cr, 3);
        chk("full_refill_count", fifo_count, 4);
        wait_idle(t_idle);

        // Reset during DATA bit 3 of 0x81 with two bytes queued
        @(negedge CLK);
        starts.delete();
        push(8'h81, '0, 1'b0, acc, cr);
        push(8'h11, '0, 1'b0, acc, cr);
        push(8'h22, '0, 1'b0, acc, cr);
        tx_valid = 1'b0;
        guard = 0;
        while (starts.size() == 0 && guard < 100) begin
            @(negedge CLK);
            guard++;
        end
        chk("abort_started", starts.size(), 1);
        t_rst = (starts.size() > 0) ? starts[0] + 17 : cyc;
        while (cyc < t_rst) @(negedge CLK);
        chk("abort_pre_txd", TXD, 0);
        RST = 1'b1;
        @(negedge CLK);
        chk("abort_txd", TXD, 1);
        chk("abort_busy", busy, 0);
        chk("abort_count", fifo_count, 0);
        RST = 1'b0;
        starts.delete();
        low_seen = 1'b0;
        repeat (100) begin
            @(negedge CLK);
            if (TXD !== 1'b1 || busy !== 1'b0) low_seen = 1'b1;
        end
        chk("abort_quiet", low_seen, 0);
        chk("abort_no_frames", starts.size(), 0);

`ifdef UART_TX_PARITY_EN
        starts.delete();
        push(8'h07, 11'b11000001110, 1'b1, acc, cr);
        tx_valid = 1'b0;
        wait_idle(t_idle);
        if (starts.size() > 0) chk("parity_frame_len", t_idle - starts[0], 44);
        @(negedge CLK);
        push(8'h03, 11'b10000000110, 1'b1, acc, cr);
        tx_valid = 1'b0;
        wait_idle(t_idle);
`endif

        repeat (5) @(negedge CLK);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Buffered 8N1 UART transmitter that drives the SOC's TXD pin, which is currently tied to 0.
- The CPU side or a bus bridge pushes bytes through a valid/ready handshake into a small FIFO.
- A baud-rate counter and a frame state machine serialise each byte LSB-first onto TXD.
- Sits in the raw CLK domain, because baud timing must not depend on the divided core clock.

Parameters:
- BAUD_DIV, 104, CLK cycles per serial bit; legal range 2..65535.
- FIFO_DEPTH, 4, byte entries in the transmit FIFO; power of two, 2..64.

Ports:
- CLK  input  1  system clock.
- RST  input  1  synchronous reset, active-high.
- tx_data  input  8  byte to send.
- tx_valid  input  1  tx_data is valid this cycle.
- tx_ready  output  1  FIFO can accept a byte; a push occurs on an edge where tx_valid & tx_ready.
- TXD  output  1  serial line; idle high.
- busy  output  1  FIFO non-empty or a frame is in progress.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  number of bytes currently queued (excludes the byte being shifted).

Behaviour:
- Reset (RST high at an edge):
  - TXD=1, busy=0, fifo_count=0.
  - FIFO pointers cleared; state=IDLE; baud counter=0.
  - tx_ready=0 while RST is high; tx_ready=1 on the first cycle after RST deasserts.
- Reset mid-frame: the frame is aborted, TXD returns to 1 at that edge, queued bytes are discarded.
- tx_ready is registered and equals !full. When full, tx_valid is ignored and no data is lost or overwritten.
- Push and pop on the same edge: fifo_count is unchanged. This is legal even when full: ready stays low that cycle, so no push is taken.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE, FIFO non-empty: pop the head into shift register sh[7:0], baud_cnt=0, bit_idx=0, go to START.
  - START: TXD=0 for BAUD_DIV cycles, then go to DATA.
  - DATA: TXD=sh[0]. Each time baud_cnt reaches BAUD_DIV-1: shift sh right, bit_idx++. After bit_idx 7 completes, go to STOP.
  - STOP: TXD=1 for BAUD_DIV cycles. At the end, if the FIFO is non-empty, pop and go directly to START with no extra idle bit; else go to IDLE.
- Baud counter: counts 0..BAUD_DIV-1 within each bit, wraps to 0 at the bit boundary, held at 0 in IDLE.
- Latency:
  - Byte accepted at edge N; fifo_count=1 after N.
  - Popped at edge N+1; TXD falls at edge N+2.
  - Frame length is exactly 10*BAUD_DIV cycles.
  - Back-to-back frames occupy 10*BAUD_DIV cycles each with zero gap.
- TXD is driven from a register. No combinational path from any input to TXD.
- busy = (state != IDLE) | (fifo_count != 0). It drops on the edge the final STOP bit completes with the FIFO empty.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- When defined:
  - A PARITY state is inserted between DATA and STOP.
  - TXD = even parity (XOR of the 8 data bits) for BAUD_DIV cycles.
  - Frame becomes 11*BAUD_DIV cycles (8E1).
- When undefined: no PARITY state and no parity logic; frame is 8N1, 10*BAUD_DIV cycles.

Test Plan:
- Reset: hold RST 3 cycles with BAUD_DIV=4 -> TXD=1, busy=0, tx_ready=0 during reset; tx_ready=1 on the first cycle after; fifo_count=0.
- Single byte 0xA5, BAUD_DIV=4:
  - TXD falls 2 cycles after the accept edge.
  - Sampling at bit centres gives 0,1,0,1,0,0,1,0,1,1.
  - busy falls 40 cycles after TXD fell.
- Burst of 0x00, 0xFF, 0x55, 0x0F, 0x3C with FIFO_DEPTH=4, tx_valid held high:
  - tx_ready drops while the FIFO is full.
  - All 5 bytes arrive in order with no lost byte.
  - Stop-to-start gap is 0 cycles.
  - Total TXD-low-to-idle time is 5*40 cycles.
- Push while full plus simultaneous pop: tx_valid=1 with fifo_count=4 at the pop edge -> byte not accepted that cycle, fifo_count 4->3; accepted the next cycle, fifo_count back to 4.
- Reset mid-frame: assert RST during DATA bit 3 of 0x81 with 2 bytes queued -> TXD=1 after that edge; after reset, no further frames are sent without a new push.
- With UART_TX_PARITY_EN defined, send 0x07 -> 9th bit=1, frame=44 cycles at BAUD_DIV=4; send 0x03 -> parity bit=0.
